// File: rtl/av1_dec_symbol_search_if.sv
// Handshake and table-read bundle between a symbol-search requester and av1_dec_symbol_search.
interface av1_dec_symbol_search_if #(
    parameter int unsigned RANGE_WIDTH = 16,
    parameter int unsigned SYM_WIDTH   = 4
);
    logic                   start;
    logic [RANGE_WIDTH-1:0] range_in;
    logic [RANGE_WIDTH-1:0] dif_in;
    logic [SYM_WIDTH:0]     nsyms;
    logic [SYM_WIDTH-1:0]   cdf_addr;
    logic [RANGE_WIDTH-1:0] cdf_data;
    logic                   busy;
    logic                   done;
    logic [SYM_WIDTH-1:0]   symbol;
    logic [RANGE_WIDTH-1:0] rng_out;
    logic [RANGE_WIDTH-1:0] v_out;
    logic                   error;

    modport master (
        output start, range_in, dif_in, nsyms, cdf_data,
        input  cdf_addr, busy, done, symbol, rng_out, v_out, error
    );

    modport slave (
        input  start, range_in, dif_in, nsyms, cdf_data,
        output cdf_addr, busy, done, symbol, rng_out, v_out, error
    );
endinterface

// File: rtl/av1_dec_symbol_search.sv
// AV1 decoder symbol search: walks the inverse CDF one entry per REQ/CMP pair to find the symbol.
// Optional request checking is built when AV1_DEC_SYM_CHECK_EN is defined.
module av1_dec_symbol_search #(
    parameter int unsigned RANGE_WIDTH = 16,
    parameter int unsigned SYM_WIDTH   = 4,
    parameter int unsigned MIN_PROB    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    av1_dec_symbol_search_if.slave   bus
);
    localparam int unsigned RW       = RANGE_WIDTH;
    localparam int unsigned SW       = SYM_WIDTH;
    localparam int unsigned NS_W     = SYM_WIDTH + 1;
    localparam int unsigned RH_W     = RW - 8;
    localparam int unsigned IC_W     = RW - 6;
    localparam int unsigned PROD_W   = RH_W + IC_W;
    localparam int unsigned V_W      = RW + 1;
    localparam int unsigned MAX_SYMS = 2 ** SYM_WIDTH;

    typedef enum logic [1:0] {IDLE, REQ, CMP} state_t;

    state_t          st_q, st_d;
    logic [RH_W-1:0] r_hi_q, r_hi_d;
    logic [RW-1:0]   c_q, c_d;
    logic [SW-1:0]   n_q, n_d;
    logic [SW-1:0]   k_q, k_d;
    logic [RW-1:0]   u_q, u_d;
    logic [SW-1:0]   addr_q, addr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [SW-1:0]   sym_q, sym_d;
    logic [RW-1:0]   rng_q, rng_d;
    logic [RW-1:0]   vout_q, vout_d;

    logic [PROD_W-1:0] prod;
    logic [V_W-1:0]    v_raw;
    logic [V_W-1:0]    v;
    logic              cont;

    // Split point for entry k; the last entry is forced to 0 so the walk always ends.
    assign prod  = PROD_W'(r_hi_q) * PROD_W'(bus.cdf_data >> 6);
    assign v_raw = V_W'(prod >> 1) + V_W'(MIN_PROB) * V_W'(n_q - k_q);
    assign v     = (k_q == n_q) ? '0 : v_raw;
    assign cont  = ({1'b0, c_q} < v) && (k_q < n_q);

`ifdef AV1_DEC_SYM_CHECK_EN
    logic error_q, error_d;
    logic chk_bad;

    assign chk_bad = (bus.nsyms < NS_W'(2)) || (bus.nsyms > NS_W'(MAX_SYMS)) ||
                     !bus.range_in[RW-1] || (bus.dif_in >= bus.range_in);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q   <= IDLE;
            r_hi_q <= '0;
            c_q    <= '0;
            n_q    <= '0;
            k_q    <= '0;
            u_q    <= '0;
            addr_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sym_q  <= '0;
            rng_q  <= '0;
            vout_q <= '0;
`ifdef AV1_DEC_SYM_CHECK_EN
            error_q <= 1'b0;
`endif
        end else begin
            st_q   <= st_d;
            r_hi_q <= r_hi_d;
            c_q    <= c_d;
            n_q    <= n_d;
            k_q    <= k_d;
            u_q    <= u_d;
            addr_q <= addr_d;
            busy_q <= busy_d;
            done_q <= done_d;
            sym_q  <= sym_d;
            rng_q  <= rng_d;
            vout_q <= vout_d;
`ifdef AV1_DEC_SYM_CHECK_EN
            error_q <= error_d;
`endif
        end
    end

    // Next state; busy stays high through the done cycle so a back-to-back start keeps it asserted.
    always_comb begin
        st_d   = st_q;
        r_hi_d = r_hi_q;
        c_d    = c_q;
        n_d    = n_q;
        k_d    = k_q;
        u_d    = u_q;
        addr_d = addr_q;
        busy_d = busy_q;
        done_d = 1'b0;
        sym_d  = sym_q;
        rng_d  = rng_q;
        vout_d = vout_q;
`ifdef AV1_DEC_SYM_CHECK_EN
        error_d = error_q;
`endif
        case (st_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
`ifdef AV1_DEC_SYM_CHECK_EN
                    error_d = chk_bad;
                    if (chk_bad) begin
                        done_d = 1'b1;
                        busy_d = 1'b1;
                        sym_d  = '0;
                        rng_d  = bus.range_in;
                        vout_d = '0;
                    end else
`endif
                    begin
                        r_hi_d = RH_W'(bus.range_in >> 8);
                        c_d    = bus.dif_in;
                        n_d    = SW'(bus.nsyms - NS_W'(1));
                        k_d    = '0;
                        u_d    = bus.range_in;
                        addr_d = '0;
                        busy_d = 1'b1;
                        st_d   = REQ;
                    end
                end
            end
            REQ: st_d = CMP;
            CMP: begin
                if (cont) begin
                    u_d    = RW'(v);
                    k_d    = k_q + SW'(1);
                    addr_d = k_q + SW'(1);
                    st_d   = REQ;
                end else begin
                    sym_d  = k_q;
                    rng_d  = RW'({1'b0, u_q} - v);
                    vout_d = RW'(v);
                    done_d = 1'b1;
                    st_d   = IDLE;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    assign bus.cdf_addr = addr_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.symbol   = sym_q;
    assign bus.rng_out  = rng_q;
    assign bus.v_out    = vout_q;
`ifdef AV1_DEC_SYM_CHECK_EN
    assign bus.error    = error_q;
`else
    assign bus.error    = 1'b0;
`endif
endmodule

// File: tb/tb_av1_dec_symbol_search.sv
// Directed plus randomised scoreboard bench for av1_dec_symbol_search with a synchronous icdf ROM.
module tb_av1_dec_symbol_search;
    localparam int unsigned RW = 16;
    localparam int unsigned SW = 4;

    logic clk = 1'b0;
    logic reset;

    av1_dec_symbol_search_if #(.RANGE_WIDTH(RW), .SYM_WIDTH(SW)) bus ();

    av1_dec_symbol_search #(.RANGE_WIDTH(RW), .SYM_WIDTH(SW), .MIN_PROB(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int icdf [16];

    always @(posedge clk) bus.cdf_data <= 16'(icdf[bus.cdf_addr]);

    typedef struct {
        int sym;
        int rng;
        int v;
        int lat;
        int err;
    } exp_t;

    exp_t sb [$];
    int   addr_log [$];
    int   errors = 0;
    int   checks = 0;
    int   exp_addr = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int r, input int c, input int ns);
        exp_t e;
        int n;
        int u;
        int v;
        e = '{default: 0};
`ifdef AV1_DEC_SYM_CHECK_EN
        if (ns < 2 || ns > 16 || r < 32768 || c >= r) begin
            e.err = 1;
            e.rng = r;
            e.lat = 1;
            return e;
        end
`endif
        n = ns - 1;
        u = r;
        for (int k = 0; k <= n; k++) begin
            if (k == n) v = 0;
            else v = (((r >> 8) * (icdf[k] >> 6)) >> 1) + 4 * (n - k);
            if (c >= v || k == n) begin
                e.sym = k;
                e.rng = (u - v) & 'hFFFF;
                e.v   = v & 'hFFFF;
                e.lat = 2 * k + 3;
                return e;
            end
            u = v;
        end
        return e;
    endfunction

    task automatic issue(input int r, input int c, input int ns);
        bus.range_in = 16'(r);
        bus.dif_in   = 16'(c);
        bus.nsyms    = 5'(ns);
        bus.start    = 1'b1;
        sb.push_back(model(r, c, ns));
    endtask

    // Waits (bounded) for done, then pops the scoreboard and compares; returns inside the done cycle.
    task automatic wait_done(input string tag, input bit poke);
        int   lat;
        bit   seen;
        exp_t e;
        lat  = 0;
        seen = 1'b0;
        addr_log.delete();
        while (!seen && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            bus.start = (poke && lat == 4);
            if (poke && lat == 4) bus.dif_in = 16'hFFFF;
            if (lat == 1) chk({tag, "_busy"}, int'(bus.busy), 1);
            if (bus.done) seen = 1'b1;
            else if (bus.busy && (addr_log.size() == 0 || addr_log[$] != int'(bus.cdf_addr)))
                addr_log.push_back(int'(bus.cdf_addr));
        end
        chk({tag, "_done_seen"}, int'(seen), 1);
        chk({tag, "_sb_nonempty"}, int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_symbol"}, int'(bus.symbol), e.sym);
            chk({tag, "_rng_out"}, int'(bus.rng_out), e.rng);
            chk({tag, "_v_out"}, int'(bus.v_out), e.v);
            chk({tag, "_latency"}, lat, e.lat);
            chk({tag, "_error"}, int'(bus.error), e.err);
            if (e.err == 0) begin
                chk({tag, "_nreads"}, addr_log.size(), e.sym + 1);
                for (int i = 0; i < addr_log.size(); i++) chk({tag, "_addr"}, addr_log[i], i);
                exp_addr = e.sym;
            end else begin
                chk({tag, "_nreads"}, addr_log.size(), 0);
                chk({tag, "_addr_hold"}, int'(bus.cdf_addr), exp_addr);
            end
        end
    endtask

    task automatic idle_check(input string tag, input int n);
        int dcount;
        dcount = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.done) dcount++;
        end
        chk({tag, "_no_done"}, dcount, 0);
        chk({tag, "_busy_low"}, int'(bus.busy), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_symbol"}, int'(bus.symbol), 0);
        chk({tag, "_rng_out"}, int'(bus.rng_out), 0);
        chk({tag, "_v_out"}, int'(bus.v_out), 0);
        chk({tag, "_cdf_addr"}, int'(bus.cdf_addr), 0);
        chk({tag, "_error"}, int'(bus.error), 0);
    endtask

    task automatic clear_icdf();
        for (int i = 0; i < 16; i++) icdf[i] = 0;
    endtask

    initial begin
        int r;
        int c;
        int ns;
        int dcount;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.range_in = '0;
        bus.dif_in   = '0;
        bus.nsyms    = '0;
        clear_icdf();
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        reset = 1'b0;
        @(posedge clk); #1;

        // Two-symbol table, c above the split: symbol 0.
        icdf[0] = 16384;
        issue(32'h8000, 32'h7000, 2);
        wait_done("two_s0", 1'b0);
        chk("two_s0_v_const", int'(bus.v_out), 16388);
        chk("two_s0_rng_const", int'(bus.rng_out), 16380);

        // Same table, c below the split: symbol 1.
        issue(32'h8000, 32'h1000, 2);
        wait_done("two_s1", 1'b0);
        chk("two_s1_rng_const", int'(bus.rng_out), 16388);

        // All-zero table, 16 symbols: walks to the last entry.
        clear_icdf();
        issue(32'hFFFF, 0, 16);
        wait_done("walk16", 1'b0);
        chk("walk16_sym_const", int'(bus.symbol), 15);

        // Last entry nonzero in the table: must still be treated as 0.
        icdf[3] = 16'hFFC0;
        issue(32'hC000, 0, 4);
        wait_done("force0", 1'b0);
        chk("force0_v_const", int'(bus.v_out), 0);

        // Back-to-back: second start in the done cycle.
        clear_icdf();
        icdf[0] = 16384;
        issue(32'h8000, 32'h1000, 2);
        wait_done("b2b_a", 1'b0);
        chk("b2b_busy_in_done", int'(bus.busy), 1);
        issue(32'h8000, 32'h7000, 2);
        wait_done("b2b_b", 1'b0);

        // Start with different inputs while busy must be ignored.
        clear_icdf();
        issue(32'hFFFF, 0, 16);
        wait_done("poke", 1'b1);
        idle_check("poke_after", 6);

        // Reset during a long search.
        issue(32'hFFFF, 0, 16);
        repeat (6) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("midrst");
        sb.delete();
        exp_addr = 0;
        @(posedge clk); #1;
        reset  = 1'b0;
        dcount = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) dcount++;
        end
        chk("midrst_no_done", dcount, 0);
        icdf[0] = 16384;
        issue(32'h8000, 32'h1000, 2);
        wait_done("post_rst", 1'b0);

`ifdef AV1_DEC_SYM_CHECK_EN
        issue(32'h8000, 32'h1000, 1);
        wait_done("err_ns1", 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("err_held", int'(bus.error), 1);
        issue(32'h9000, 32'h9000, 2);
        wait_done("err_dif", 1'b0);
        issue(32'h7FFF, 0, 2);
        wait_done("err_rng", 1'b0);
        issue(32'h8000, 32'h7000, 2);
        wait_done("err_clear", 1'b0);
`endif

        // Randomised non-increasing tables.
        for (int t = 0; t < 8; t++) begin
            icdf[0] = $urandom_range(32000, 0);
            for (int k = 1; k < 16; k++) icdf[k] = icdf[k-1] - $urandom_range(icdf[k-1], 0);
            r  = $urandom_range(65535, 32768);
            c  = $urandom_range(r - 1, 0);
            ns = $urandom_range(16, 2);
            issue(r, c, ns);
            wait_done("rand", 1'b0);
            idle_check("rand_gap", 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
